// File: rtl/gen_pkg.sv
// Shared Genius datapath constants: symbol geometry defaults, colour codes
// and the length-counter width helper.
package gen_pkg;

  localparam int unsigned SYM_W_DEF = 4;
  localparam int unsigned DEPTH_DEF = 16;

  localparam logic [SYM_W_DEF-1:0] RED    = 4'h1;
  localparam logic [SYM_W_DEF-1:0] GREEN  = 4'h2;
  localparam logic [SYM_W_DEF-1:0] BLUE   = 4'h3;
  localparam logic [SYM_W_DEF-1:0] YELLOW = 4'h4;

  function automatic int unsigned len_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/seq_store.sv
// Symbol-sequence register: parallel load, append, clear, read pointer for
// playback and an in-place compare port for player input.
module seq_store
  import gen_pkg::*;
#(
  parameter int unsigned SYM_W = SYM_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                        clk_i,
  input  logic                        r_n_i,
  input  logic                        clr_i,
  input  logic                        load_i,
  input  logic [SYM_W*DEPTH-1:0]      data_i,
  input  logic                        push_i,
  input  logic [SYM_W-1:0]            push_sym_i,
  input  logic                        rd_start_i,
  input  logic                        rd_next_i,
  input  logic                        chk_i,
  input  logic [SYM_W-1:0]            chk_sym_i,
  output logic [SYM_W*DEPTH-1:0]      q_o,
  output logic [SYM_W-1:0]            head_o,
  output logic [SYM_W-1:0]            rd_sym_o,
  output logic                        rd_valid_o,
  output logic [len_w(DEPTH)-1:0]     len_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic                        match_o,
  output logic                        miss_o,
  output logic                        done_o,
  output logic                        ovf_o
);

  localparam int unsigned N     = SYM_W * DEPTH;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LEN_W = len_w(DEPTH);

  logic [N-1:0]     mem_q, mem_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic             match_q, match_d;
  logic             miss_q, miss_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic [SYM_W-1:0] rd_sym;
  logic             rd_valid;
  logic             full;
  logic             rp_can_adv;

  // Pointer compares are done one bit wider than the length so rp+1 never wraps.
  assign rd_valid   = ({1'b0, (LEN_W)'(rp_q)}) < {1'b0, len_q};
  assign rp_can_adv = ((LEN_W+1)'(rp_q) + (LEN_W+1)'(1)) < {1'b0, len_q};
  assign full       = (len_q == LEN_W'(DEPTH));

  always_comb begin
    rd_sym = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (PTR_W'(k) == rp_q) rd_sym = mem_q[N-1-k*SYM_W -: SYM_W];
    end
  end

  always_comb begin
    mem_d   = mem_q;
    len_d   = len_q;
    rp_d    = rp_q;
    match_d = 1'b0;
    miss_d  = 1'b0;
    done_d  = 1'b0;
    ovf_d   = 1'b0;

    if (clr_i) begin
      mem_d = '0;
      len_d = '0;
      rp_d  = '0;
    end else if (load_i) begin
      mem_d = data_i;
      len_d = LEN_W'(DEPTH);
      rp_d  = '0;
    end else begin
      if (push_i) begin
        if (!full) begin
          for (int unsigned k = 0; k < DEPTH; k++) begin
            if (LEN_W'(k) == len_q) mem_d[N-1-k*SYM_W -: SYM_W] = push_sym_i;
          end
          len_d = len_q + LEN_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end

      // Read side sees pre-edge mem; a concurrent push only writes index len > rp.
      if (rd_start_i) begin
        rp_d = '0;
      end else if (chk_i) begin
        if (rd_valid && (chk_sym_i == rd_sym)) begin
          match_d = 1'b1;
          if (rp_can_adv) rp_d = rp_q + PTR_W'(1);
          else            done_d = 1'b1;
        end else begin
          miss_d = 1'b1;
        end
      end else if (rd_next_i) begin
        if (rp_can_adv) rp_d = rp_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge r_n_i) begin
    if (!r_n_i) begin
      mem_q   <= '0;
      len_q   <= '0;
      rp_q    <= '0;
      match_q <= 1'b0;
      miss_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      len_q   <= len_d;
      rp_q    <= rp_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q_o        = mem_q;
  assign head_o     = mem_q[N-1 -: SYM_W];
  assign rd_sym_o   = rd_sym;
  assign rd_valid_o = rd_valid;
  assign len_o      = len_q;
  assign full_o     = full;
  assign empty_o    = (len_q == '0);
  assign match_o    = match_q;
  assign miss_o     = miss_q;
  assign done_o     = done_q;
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_seq_store.sv
// Scoreboard bench for seq_store: a behavioural array model predicts the
// post-edge outputs of every driven cycle.
module tb_seq_store;
  import gen_pkg::*;

  logic        clk = 1'b0;
  logic        r_n = 1'b0;
  logic        clr = 1'b0, load = 1'b0, push = 1'b0;
  logic        rds = 1'b0, rdn = 1'b0, chk = 1'b0;
  logic [63:0] data = '0;
  logic [3:0]  psym = '0, csym = '0;
  logic [63:0] q;
  logic [3:0]  head, rd_sym;
  logic [4:0]  len;
  logic        rd_valid, full, empty, match, miss, done, ovf;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  seq_store #(.SYM_W(4), .DEPTH(16)) dut (
    .clk_i(clk), .r_n_i(r_n), .clr_i(clr), .load_i(load), .data_i(data),
    .push_i(push), .push_sym_i(psym), .rd_start_i(rds), .rd_next_i(rdn),
    .chk_i(chk), .chk_sym_i(csym), .q_o(q), .head_o(head), .rd_sym_o(rd_sym),
    .rd_valid_o(rd_valid), .len_o(len), .full_o(full), .empty_o(empty),
    .match_o(match), .miss_o(miss), .done_o(done), .ovf_o(ovf)
  );

  typedef struct {
    logic [63:0] q;
    logic [3:0]  head, rd_sym;
    logic        rd_valid;
    logic [4:0]  len;
    logic        full, empty, match, miss, done, ovf;
  } exp_t;

  exp_t sbq[$];

  logic [3:0] m_mem [16];
  int         m_len, m_rp;
  logic       m_match, m_miss, m_done, m_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_len = 0; m_rp = 0;
    m_match = 0; m_miss = 0; m_done = 0; m_ovf = 0;
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e.q = '0;
    for (int i = 0; i < 16; i++) e.q[63-4*i -: 4] = m_mem[i];
    e.head     = m_mem[0];
    e.rd_sym   = m_mem[m_rp];
    e.rd_valid = (m_rp < m_len);
    e.len      = 5'(m_len);
    e.full     = (m_len == 16);
    e.empty    = (m_len == 0);
    e.match = m_match; e.miss = m_miss; e.done = m_done; e.ovf = m_ovf;
    return e;
  endfunction

  task automatic model_step();
    int ol;
    ol = m_len;
    m_match = 0; m_miss = 0; m_done = 0; m_ovf = 0;
    if (clr) begin
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      m_len = 0; m_rp = 0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) m_mem[i] = data[63-4*i -: 4];
      m_len = 16; m_rp = 0;
    end else begin
      if (rds) m_rp = 0;
      else if (chk) begin
        if (m_rp < ol && csym == m_mem[m_rp]) begin
          m_match = 1;
          if (m_rp + 1 < ol) m_rp++;
          else m_done = 1;
        end else m_miss = 1;
      end else if (rdn) begin
        if (m_rp + 1 < ol) m_rp++;
      end
      if (push) begin
        if (ol < 16) begin m_mem[ol] = psym; m_len = ol + 1; end
        else m_ovf = 1;
      end
    end
  endtask

  task automatic compare_outputs(input exp_t e);
    check("q", q, e.q);
    check("head", 64'(head), 64'(e.head));
    check("rd_sym", 64'(rd_sym), 64'(e.rd_sym));
    check("rd_valid", 64'(rd_valid), 64'(e.rd_valid));
    check("len", 64'(len), 64'(e.len));
    check("full", 64'(full), 64'(e.full));
    check("empty", 64'(empty), 64'(e.empty));
    check("match", 64'(match), 64'(e.match));
    check("miss", 64'(miss), 64'(e.miss));
    check("done", 64'(done), 64'(e.done));
    check("ovf", 64'(ovf), 64'(e.ovf));
  endtask

  // Inputs are already set; predict, advance one edge, compare.
  task automatic cycle();
    exp_t e;
    model_step();
    sbq.push_back(model_outputs());
    @(posedge clk);
    #1;
    if (sbq.size() == 0) check("sb_empty", 64'(1), 64'(0));
    else begin
      e = sbq.pop_front();
      compare_outputs(e);
    end
    {clr, load, push, rds, rdn, chk} = '0;
  endtask

  task automatic do_push(input logic [3:0] s);
    push = 1; psym = s; cycle();
  endtask

  task automatic do_chk(input logic [3:0] s);
    chk = 1; csym = s; cycle();
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_q", q, 64'd0);
    check("rst_empty", 64'(empty), 64'(1));
    check("rst_valid", 64'(rd_valid), 64'(0));
    r_n = 1'b1;
    for (int i = 0; i < 10; i++) cycle();

    do_push(RED); do_push(GREEN); do_push(BLUE);
    check("len3", 64'(len), 64'd3);
    check("head1", 64'(head), 64'h1);
    begin
      logic [11:0] top;
      top = q[63:52];
      check("q_top", 64'(top), 64'h123);
    end
    rds = 1; cycle();
    check("rd0", 64'(rd_sym), 64'h1);
    rdn = 1; cycle();
    rdn = 1; cycle();
    check("rd2", 64'(rd_sym), 64'h3);
    rdn = 1; cycle();
    check("rd_hold", 64'(rd_sym), 64'h3);

    rds = 1; cycle();
    do_chk(RED); do_chk(GREEN); do_chk(BLUE);
    check("done3", 64'(done), 64'(1));
    rds = 1; cycle();
    do_chk(RED);
    do_chk(YELLOW);
    check("miss4", 64'(miss), 64'(1));
    check("rp_kept", 64'(rd_sym), 64'h2);

    load = 1; data = 64'hFEDC_BA98_7654_3210; cycle();
    check("ld_len", 64'(len), 64'd16);
    check("ld_head", 64'(head), 64'hF);
    do_push(4'h5);
    check("ovf", 64'(ovf), 64'(1));
    check("ovf_q", q, 64'hFEDC_BA98_7654_3210);

    clr = 1; load = 1; push = 1; psym = 4'h9; cycle();
    check("clr_pri", 64'(empty), 64'(1));
    do_push(4'h7); do_push(4'h8);
    rdn = 1; cycle();
    rds = 1; chk = 1; csym = 4'hF; cycle();
    check("rds_pri_miss", 64'(miss), 64'(0));
    check("rds_pri_rp", 64'(rd_sym), 64'h7);

    // push and chk together
    push = 1; psym = 4'hA; chk = 1; csym = 4'h7; cycle();

    // asynchronous reset in the middle of a push burst
    clr = 1; cycle();
    do_push(4'h1); do_push(4'h2);
    push = 1; psym = 4'h3;
    #3 r_n = 1'b0;
    #1;
    check("arst_len", 64'(len), 64'd0);
    check("arst_q", q, 64'd0);
    check("arst_empty", 64'(empty), 64'(1));
    model_reset();
    push = 0;
    @(posedge clk); #1;
    r_n = 1'b1;
    for (int i = 0; i < 17; i++) do_push(4'(i + 1));
    check("burst_full", 64'(full), 64'(1));

    for (int i = 0; i < 400; i++) begin
      clr  = ($urandom_range(0, 31) == 0);
      load = ($urandom_range(0, 31) == 0);
      data = {$urandom, $urandom};
      push = ($urandom_range(0, 3) == 0);
      psym = 4'($urandom_range(0, 3));
      rds  = ($urandom_range(0, 7) == 0);
      rdn  = ($urandom_range(0, 3) == 0);
      chk  = ($urandom_range(0, 1) == 0);
      csym = 4'($urandom_range(0, 3));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, got %0d expected 0 pending", sbq.size());
    $fatal(1);
  end

endmodule

// File: doc/seq_store.md
# seq_store

Parametrised symbol-sequence register for the Genius game datapath, successor to the flat 64-bit sequence register. It holds up to DEPTH symbols of SYM_W bits and supports parallel load, single-symbol append and clear. It also provides a read pointer for LED playback and an in-place compare port for checking player input. It sits between the random-symbol source and the game controller FSM.

## Interface
- SYM_W, 4, bits per symbol (colour code)
- DEPTH, 16, maximum sequence length in symbols (DEPTH >= 2); N = SYM_W*DEPTH
- clk_i  in  1  system clock, all state on rising edge
- r_n_i  in  1  asynchronous, active-low reset
- clr_i  in  1  empty the sequence
- load_i  in  1  parallel load of data_i
- data_i  in  N  parallel load data; symbol 0 in MSBs
- push_i  in  1  append push_sym_i at tail
- push_sym_i  in  SYM_W  symbol to append
- rd_start_i  in  1  read pointer to symbol 0
- rd_next_i  in  1  advance read pointer
- chk_i  in  1  compare chk_sym_i against symbol at read pointer
- chk_sym_i  in  SYM_W  player symbol
- q_o  out  N  full storage image; symbol k at q_o[N-1-k*SYM_W -: SYM_W]
- head_o  out  SYM_W  symbol 0 (= q_o[N-1 -: SYM_W])
- rd_sym_o  out  SYM_W  symbol at read pointer
- rd_valid_o  out  1  read pointer < len
- len_o  out  LEN_W  current length, LEN_W = $clog2(DEPTH+1)
- full_o / empty_o  out  1  len == DEPTH / len == 0
- match_o / miss_o / done_o / ovf_o  out  1  one-cycle registered pulses

## Operation
- State: symbol array mem[0..DEPTH-1], length len, read pointer rp (PTR_W = $clog2(DEPTH)), pulse flops.
- Write-side priority per cycle: clr_i > load_i > push_i.
  - clr: len <= 0 and rp <= 0; mem is zeroed.
  - load: mem <= data_i, len <= DEPTH, rp <= 0.
  - push, !full: mem[len] <= push_sym_i, len <= len+1.
  - push while full: no change, ovf_o pulses.
- Read-side priority: rd_start_i > chk_i > rd_next_i. All read-side ops are ignored in a cycle where clr or load is taken.
  - rd_start: rp <= 0.
  - rd_next: rp <= rp+1 only if rp+1 < len; otherwise rp holds.
  - chk with rp < len:
    - chk_sym_i == mem[rp]: match_o pulses, and rp advances under the same rule as rd_next.
    - If that match was at rp == len-1, done_o also pulses and rp holds.
    - Mismatch: miss_o pulses and rp holds.
  - chk with rp >= len: miss_o pulses.
- Simultaneous push and chk are both executed. chk compares against pre-edge mem; the push writes index len > rp, so they cannot conflict.
- rd_sym_o = mem[rp] and rd_valid_o = (rp < len), both combinational from registered state.
- head_o, q_o, full_o, empty_o and len_o are combinational from registered state.

## Timing
- Reset (r_n_i low, asynchronous): mem = 0, len = 0, rp = 0, all pulses 0. Consequently q_o = 0, head_o = 0, rd_sym_o = 0, empty_o = 1, full_o = 0, rd_valid_o = 0.
- Reset asserted mid-operation aborts everything immediately. There is no partial update.
- Every write/read op takes effect at the edge where it is sampled. Outputs reflect it in the following cycle (latency 1).
- match/miss/done/ovf are high for exactly one cycle after the sampling edge. They are never asserted in a cycle without the causing request on the previous edge.
- Back-to-back ops every cycle are allowed: push each cycle until full, chk each cycle.

## Structure
- Shared package gen_pkg: SYM_W/DEPTH defaults, the colour symbol constants (RED, GREEN, BLUE, YELLOW) and an LEN_W helper function.
- A single module is natural.
- The symbol array is a flat N-bit register, indexed by part-select, so q_o needs no extra logic.

## Test plan
- Reset then idle: q_o = 0, len_o = 0, empty_o = 1, rd_valid_o = 0; all pulses stay 0 for 10 cycles.
- Push 1,2,3 in three consecutive cycles -> len_o = 3, head_o = 1, q_o[63:52] = 0x123; rd_start then rd_next x2 -> rd_sym_o 1,2,3; a further rd_next holds at 3.
- After the previous scenario: rd_start, then chk 1,2,3 -> match_o on each, done_o with the third; a new sequence chk 1 then chk 4 -> match_o, then miss_o with rp unchanged (rd_sym_o = 2).
- load_i with data_i = 0xFEDC_BA98_7654_3210 -> len_o = 16, full_o = 1, head_o = 0xF; push 5 -> ovf_o pulse, q_o unchanged.
- Same cycle clr_i + load_i + push_i -> empty_o = 1, len_o = 0; same cycle rd_start_i + chk_i with a wrong symbol -> rp = 0, no miss_o.
- Assert r_n_i low between clock edges during a push burst -> outputs go to reset values before the next edge; the burst resumes from len = 0 after release.
